// File: rtl/vga_pkg.sv
// Shared VGA constants and small types used by the frame-fetch pipeline.
package vga_pkg;
  localparam int H_ACTIVE      = 640;
  localparam int V_ACTIVE      = 480;
  localparam int H_TOTAL       = 800;
  localparam int V_TOTAL       = 525;
  localparam int FETCH_LATENCY = 2;
  localparam int COLOR_W       = 4;

  typedef logic [COLOR_W-1:0] color_t;

  typedef struct packed {
    logic h_sync;
    logic v_sync;
  } sync_t;

  // Per-pixel attributes carried alongside the BRAM read for one stage.
  typedef struct packed {
    logic video_on;
    logic in_img;
    logic h_lsb;
    logic v_lsb;
  } pix_tag_t;

  // 2x2 ordered-dither offset indexed by {v[0],h[0]}.
  function automatic logic [7:0] dither_off(input logic v0, input logic h0);
    case ({v0, h0})
      2'b00:   return 8'd0;
      2'b01:   return 8'd8;
      2'b10:   return 8'd12;
      default: return 8'd4;
    endcase
  endfunction
endpackage

// File: rtl/vga_frame_fetch_if.sv
// Frame-buffer read port: registered address out, 8-bit grayscale data back one clock later.
interface vga_frame_fetch_if #(parameter int ADDR_W = 14);
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;

  modport master (output rd_addr, input rd_data);
  modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/vga_addr_gen.sv
// Incremental frame-buffer address generator with 2^SCALE_LOG2 pixel/line replication.
module vga_addr_gen #(
  parameter int IMG_W      = 128,
  parameter int SCALE_LOG2 = 1,
  parameter int ADDR_W     = 14
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pix_en,
  input  logic              in_img,
  input  logic              row_end,
  input  logic              v_zero,
  output logic [ADDR_W-1:0] rd_addr
);
  localparam logic [1:0] SUB_MAX = 2'((1 << SCALE_LOG2) - 1);

  logic [1:0]        sub_x, sub_y;
  logic [ADDR_W-1:0] col, row_base;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr  <= '0;
      sub_x    <= '0;
      sub_y    <= '0;
      col      <= '0;
      row_base <= '0;
    end else if (pix_en) begin
      if (in_img) rd_addr <= row_base + col;
      // Frame restart; skipped for in-image pixels so IMG_Y0=0 still works.
      if (v_zero && !in_img) begin
        sub_x    <= '0;
        col      <= '0;
        sub_y    <= '0;
        row_base <= '0;
      end else if (row_end) begin
        sub_x <= '0;
        col   <= '0;
        if (sub_y == SUB_MAX) begin
          sub_y    <= '0;
          row_base <= row_base + ADDR_W'(IMG_W);
        end else begin
          sub_y <= sub_y + 2'd1;
        end
      end else if (in_img) begin
        if (sub_x == SUB_MAX) begin
          sub_x <= '0;
          col   <= col + 1'b1;
        end else begin
          sub_x <= sub_x + 2'd1;
        end
      end
    end
  end
endmodule

// File: rtl/vga_frame_fetch.sv
// Grayscale frame-buffer pixel source for the VGA output stage, 2 pix_en ticks of latency.
// Optional DITHER_EN: 2x2 ordered dither with saturation before truncating to 4 bits.
module vga_frame_fetch
  import vga_pkg::*;
#(
  parameter int           IMG_W      = 128,
  parameter int           IMG_H      = 128,
  parameter int           SCALE_LOG2 = 1,
  parameter int           IMG_X0     = 192,
  parameter int           IMG_Y0     = 112,
  parameter logic [COLOR_W-1:0] BG_LEVEL = 4'h2,
  parameter int           ADDR_W     = 14
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               pix_en,
  input  logic [9:0]         h_count,
  input  logic [9:0]         v_count,
  input  logic               video_on,
  input  logic               h_sync_in,
  input  logic               v_sync_in,
  vga_frame_fetch_if.master  fb,
  output logic               h_sync,
  output logic               v_sync,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b
);
  localparam logic [10:0] X_LO = 11'(IMG_X0);
  localparam logic [10:0] X_HI = 11'(IMG_X0 + (IMG_W << SCALE_LOG2));
  localparam logic [10:0] Y_LO = 11'(IMG_Y0);
  localparam logic [10:0] Y_HI = 11'(IMG_Y0 + (IMG_H << SCALE_LOG2));

  logic in_img, row_end, v_zero;
  logic [ADDR_W-1:0] addr;

  assign in_img  = video_on
                && ({1'b0, h_count} >= X_LO) && ({1'b0, h_count} < X_HI)
                && ({1'b0, v_count} >= Y_LO) && ({1'b0, v_count} < Y_HI);
  assign row_end = in_img && ({1'b0, h_count} == X_HI - 11'd1);
  assign v_zero  = (v_count == '0);

  vga_addr_gen #(
    .IMG_W      (IMG_W),
    .SCALE_LOG2 (SCALE_LOG2),
    .ADDR_W     (ADDR_W)
  ) u_addr_gen (
    .clock   (clock),
    .reset_n (reset_n),
    .pix_en  (pix_en),
    .in_img  (in_img),
    .row_end (row_end),
    .v_zero  (v_zero),
    .rd_addr (addr)
  );
  assign fb.rd_addr = addr;

  // S1 tag travels with the BRAM read; syncs ride a FETCH_LATENCY-deep shift register.
  pix_tag_t                     tag_s1;
  sync_t [FETCH_LATENCY-1:0]    sync_pipe;
  color_t                       color_q, color_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_s1    <= '0;
      sync_pipe <= '1;
    end else if (pix_en) begin
      tag_s1    <= {video_on, in_img, h_count[0], v_count[0]};
      sync_pipe <= {sync_pipe[FETCH_LATENCY-2:0], sync_t'({h_sync_in, v_sync_in})};
    end
  end

  logic [7:0] pix;
  logic       unused;
`ifdef DITHER_EN
  logic [8:0] sum;
  assign sum    = {1'b0, fb.rd_data} + {1'b0, dither_off(tag_s1.v_lsb, tag_s1.h_lsb)};
  assign pix    = sum[8] ? 8'hFF : sum[7:0];
  assign unused = ^pix[3:0];
`else
  assign pix    = fb.rd_data;
  assign unused = ^{pix[3:0], tag_s1.h_lsb, tag_s1.v_lsb};
`endif

  always_comb begin
    color_d = '0;
    if (tag_s1.video_on) color_d = tag_s1.in_img ? pix[7:4] : BG_LEVEL;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    color_q <= '0;
    else if (pix_en) color_q <= color_d;
  end

  assign h_sync = sync_pipe[FETCH_LATENCY-1].h_sync;
  assign v_sync = sync_pipe[FETCH_LATENCY-1].v_sync;
  assign vga_r  = color_q;
  assign vga_g  = color_q;
  assign vga_b  = color_q;
endmodule
